// File: rtl/saradc_11b_dig_sucal_if.sv
// Calibration port bundle between the startup sequencer / analog core and the
// startup-calibration engine. Signal names match the original flat ports.
interface saradc_11b_dig_sucal_if #(
  parameter int unsigned TRIM_W = 6
);
  logic              enable_fsms_i;
  logic              sucal_i;
  logic              comp_i;
  logic              cal_active_o;
  logic [TRIM_W-1:0] trim_o;
  logic              sucal_done_o;

  modport master (
    output enable_fsms_i, sucal_i, comp_i,
    input  cal_active_o, trim_o, sucal_done_o
  );

  modport slave (
    input  enable_fsms_i, sucal_i, comp_i,
    output cal_active_o, trim_o, sucal_done_o
  );
endinterface

// File: rtl/saradc_11b_dig_sucal.sv
// Startup calibration: SAR search of the comparator offset-trim code.
// Define SARADC_11B_SUCAL_MAJORITY_EN for 2-of-3 majority voting per bit decision.
module saradc_11b_dig_sucal #(
  parameter int unsigned TRIM_W     = 6,
  parameter int unsigned SETTLE_CYC = 4
) (
  input  logic                   clk,
  input  logic                   nres,
  saradc_11b_dig_sucal_if.slave  sucal_if
);

  localparam int unsigned KW = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;
  localparam logic [TRIM_W-1:0] TRIM_MID = {1'b1, {(TRIM_W-1){1'b0}}};
  localparam logic [KW-1:0]     K_TOP    = KW'(TRIM_W - 1);
  localparam logic [3:0]        CNT_LOAD = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SET,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t            r_state;
  logic [KW-1:0]     r_k;
  logic [3:0]        r_cnt;
  logic              r_cal;
  logic [TRIM_W-1:0] r_trim;
  logic              r_done;

  logic              w_last;
  logic              w_dec;
  logic              w_start;

  assign w_start = sucal_if.enable_fsms_i & sucal_if.sucal_i;

`ifdef SARADC_11B_SUCAL_MAJORITY_EN
  logic [1:0] r_votes;
  logic [2:0] w_sum;

  // r_cnt doubles as the sample-phase index: it is 0 on entry to ST_SAMPLE.
  assign w_sum  = {1'b0, r_votes} + {2'b00, sucal_if.comp_i};
  assign w_last = (r_cnt == 4'd2);
  assign w_dec  = (w_sum >= 3'd2);
`else
  assign w_last = 1'b1;
  assign w_dec  = sucal_if.comp_i;
`endif

  always_ff @(posedge clk or negedge nres) begin
    if (!nres) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_cal   <= 1'b0;
      r_trim  <= TRIM_MID;
      r_done  <= 1'b0;
`ifdef SARADC_11B_SUCAL_MAJORITY_EN
      r_votes <= '0;
`endif
    end else if (!sucal_if.enable_fsms_i) begin
      r_state <= ST_IDLE;
      r_k     <= '0;
      r_cnt   <= '0;
      r_cal   <= 1'b0;
      r_trim  <= TRIM_MID;
      r_done  <= 1'b0;
`ifdef SARADC_11B_SUCAL_MAJORITY_EN
      r_votes <= '0;
`endif
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start) begin
            r_cal   <= 1'b1;
            r_done  <= 1'b0;
            r_trim  <= '0;
            r_k     <= K_TOP;
            r_state <= ST_SET;
          end
        end
        ST_SET: begin
          r_trim[r_k] <= 1'b1;
          r_cnt       <= CNT_LOAD;
          r_state     <= ST_SETTLE;
        end
        ST_SETTLE: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_SAMPLE;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        ST_SAMPLE: begin
          if (w_last) begin
            if (w_dec) begin
              r_trim[r_k] <= 1'b0;
            end
            if (r_k == '0) begin
              r_cal   <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_k     <= r_k - KW'(1);
              r_state <= ST_SET;
            end
`ifdef SARADC_11B_SUCAL_MAJORITY_EN
            r_votes <= '0;
            r_cnt   <= '0;
          end else begin
            r_votes <= r_votes + {1'b0, sucal_if.comp_i};
            r_cnt   <= r_cnt + 4'd1;
`endif
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign sucal_if.cal_active_o = r_cal;
  assign sucal_if.trim_o       = r_trim;
  assign sucal_if.sucal_done_o = r_done;

endmodule

// File: tb/tb_saradc_11b_dig_sucal.sv
// Self-checking bench for saradc_11b_dig_sucal: comparator model drives comp_i,
// expected trim/latency pairs are queued at request time and checked at done.
module tb_saradc_11b_dig_sucal;

`ifdef SARADC_11B_SUCAL_MAJORITY_EN
  localparam int S   = 3;
  localparam bit MAJ = 1'b1;
`else
  localparam int S   = 1;
  localparam bit MAJ = 1'b0;
`endif
  localparam int TRIM_W = 6;
  localparam int SETTLE = 4;
  localparam int BITP   = 1 + SETTLE + S;
  localparam int LAT    = TRIM_W * BITP;

  logic clk = 1'b0;
  logic nres;
  always #5 clk = ~clk;

  saradc_11b_dig_sucal_if #(.TRIM_W(TRIM_W)) u_if ();

  saradc_11b_dig_sucal #(
    .TRIM_W    (TRIM_W),
    .SETTLE_CYC(SETTLE)
  ) u_dut (
    .clk     (clk),
    .nres    (nres),
    .sucal_if(u_if)
  );

  typedef struct {
    int trim;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   edge_cnt = 0;
  int   thr = 37;
  bit   flip_en = 1'b0;

  task automatic chk(input string tag, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Monotonic comparator; in majority builds the first of the 3 samples of each bit is wrong.
  function automatic logic comp_model(input int tr, input int e);
    logic c;
    c = (tr > thr);
    if (flip_en && ((e % BITP) == (1 + SETTLE + 1) % BITP)) c = ~c;
    return c;
  endfunction

  task automatic step();
    @(posedge clk);
    edge_cnt++;
    #1;
    u_if.comp_i = comp_model(int'(u_if.trim_o), edge_cnt + 1);
  endtask

  task automatic start_req(input bit push, input int t, input int exp_trim);
    exp_t e;
    thr = t;
    flip_en = MAJ;
    u_if.sucal_i = 1'b1;
    edge_cnt = -1;
    step();
    u_if.sucal_i = 1'b0;
    if (push) begin
      e.trim = exp_trim;
      e.lat  = LAT;
      sb.push_back(e);
    end
  endtask

  task automatic run_cal(input int t, input int exp_trim, input int mid_req);
    int   done_at;
    int   cal_ok;
    exp_t e;
    start_req(1'b1, t, exp_trim);
    chk("req_trim", int'(u_if.trim_o), 0);
    chk("req_done", int'(u_if.sucal_done_o), 0);
    chk("req_cal", int'(u_if.cal_active_o), 1);
    done_at = -1;
    cal_ok  = 1;
    for (int i = 0; i < 200 && done_at < 0; i++) begin
      if (mid_req > 0 && edge_cnt == mid_req - 1) u_if.sucal_i = 1'b1;
      step();
      u_if.sucal_i = 1'b0;
      if (u_if.sucal_done_o === 1'b1) done_at = edge_cnt;
      else if (u_if.cal_active_o !== 1'b1) cal_ok = 0;
    end
    e = sb.pop_front();
    if (done_at < 0) begin
      chk("done_timeout", 0, 1);
    end else begin
      chk("done_edge", done_at, e.lat);
      chk("result_trim", int'(u_if.trim_o), e.trim);
      chk("cal_fall", int'(u_if.cal_active_o), 0);
      chk("cal_held", cal_ok, 1);
    end
    flip_en = 1'b0;
  endtask

  initial begin
    nres = 1'b0;
    u_if.enable_fsms_i = 1'b0;
    u_if.sucal_i       = 1'b0;
    u_if.comp_i        = 1'b0;
    #23;
    chk("rst_trim", int'(u_if.trim_o), 32);
    chk("rst_done", int'(u_if.sucal_done_o), 0);
    chk("rst_cal", int'(u_if.cal_active_o), 0);
    nres = 1'b1;
    step();
    u_if.enable_fsms_i = 1'b1;

    repeat (50) step();
    chk("noreq_trim", int'(u_if.trim_o), 32);
    chk("noreq_done", int'(u_if.sucal_done_o), 0);

    run_cal(37, 37, 0);
    run_cal(-1, 0, 0);
    run_cal(63, 63, 0);
    run_cal(37, 37, 10);
    repeat (3) step();
    chk("done_hold", int'(u_if.sucal_done_o), 1);
    run_cal(5, 5, 0);
    run_cal(50, 50, 0);

    start_req(1'b0, 37, 0);
    repeat (19) step();
    u_if.enable_fsms_i = 1'b0;
    step();
    chk("abort_trim", int'(u_if.trim_o), 32);
    chk("abort_cal", int'(u_if.cal_active_o), 0);
    chk("abort_done", int'(u_if.sucal_done_o), 0);
    u_if.sucal_i = 1'b1;
    step();
    u_if.sucal_i = 1'b0;
    repeat (5) step();
    chk("dis_req_cal", int'(u_if.cal_active_o), 0);
    chk("dis_req_trim", int'(u_if.trim_o), 32);
    u_if.enable_fsms_i = 1'b1;
    step();

    start_req(1'b0, 37, 0);
    repeat (15) step();
    #2 nres = 1'b0;
    #1;
    chk("nres_trim", int'(u_if.trim_o), 32);
    chk("nres_cal", int'(u_if.cal_active_o), 0);
    chk("nres_done", int'(u_if.sucal_done_o), 0);
    #2 nres = 1'b1;
    step();
    run_cal(37, 37, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
